// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Multi-cycle data-memory responder for the Y86-64 memory stage.
//               Accepts one 8-byte little-endian load/store per handshake,
//               responds LAT cycles later with read data and an address-error
//               flag (SADR source). Backing store is an internal byte array.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
  parameter int MEM_BYTES = 1024,
  parameter int LAT       = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_error,
  output logic        busy
);

  localparam int          AW       = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam int          CW       = $clog2(LAT + 1);
  localparam logic [63:0] LAST_OK  = 64'(MEM_BYTES - 8);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           wr_q, wr_d;
  logic [63:0]    addr_q, addr_d;
  logic [63:0]    wdata_q, wdata_d;
  logic [63:0]    rdata_q, rdata_d;
  logic           err_q, err_d;

  logic [7:0]     mem_q [MEM_BYTES];

  // Access strobe and the request it applies to (captured copy, or the live
  // request when the access happens on the accepting edge with LAT == 1).
  logic           acc_do;
  logic           acc_wr;
  logic [63:0]    acc_addr;
  logic [63:0]    acc_wdata;
  logic           acc_err;
  logic [AW-1:0]  acc_base;
  logic [63:0]    acc_rdata;

  // Next-state, capture and response-register decode
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    acc_do    = 1'b0;
    acc_wr    = wr_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          wr_d    = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (LAT == 1) begin
            state_d   = S_RESP;
            acc_do    = 1'b1;
            acc_wr    = req_write;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CW'(LAT - 1);
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          acc_do  = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Address check and little-endian gather of the addressed 8 bytes
  always_comb begin
    acc_err   = (acc_addr > LAST_OK);
    acc_base  = acc_addr[AW-1:0];
    acc_rdata = '0;
    for (int i = 0; i < 8; i++) begin
      acc_rdata[8*i +: 8] = mem_q[acc_base + AW'(i)];
    end
    rdata_d = rdata_q;
    err_d   = err_q;
    if (acc_do) begin
      err_d   = acc_err;
      rdata_d = (acc_err || acc_wr) ? 64'd0 : acc_rdata;
    end
  end

  // State, counter, captured request and response registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Store commit; suppressed by reset so an uncommitted store is dropped
  always_ff @(posedge clock) begin
    if (!reset && acc_do && acc_wr && !acc_err) begin
      for (int i = 0; i < 8; i++) begin
        mem_q[acc_base + AW'(i)] <= acc_wdata[8*i +: 8];
      end
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign busy      = (state_q != S_IDLE);
  assign rsp_rdata = rdata_q;
  assign rsp_error = err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Self-checking bench for dmem_responder. Instance 0 uses LAT=3,
//               instance 1 uses LAT=1; both MEM_BYTES=1024. A transaction-level
//               model predicts every output each cycle; directed sequences add
//               literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid [2];
  logic        req_write [2];
  logic [63:0] req_addr  [2];
  logic [63:0] req_wdata [2];
  logic        rsp_ready [2];
  logic        req_ready [2];
  logic        rsp_valid [2];
  logic [63:0] rsp_rdata [2];
  logic        rsp_error [2];
  logic        busy      [2];

  int nchk  = 0;
  int npass = 0;
  int cyc   = 0;

  dmem_responder #(.MEM_BYTES(1024), .LAT(3)) u_dut3 (
    .clock(clk), .reset(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_error(rsp_error[0]), .busy(busy[0])
  );

  dmem_responder #(.MEM_BYTES(1024), .LAT(1)) u_dut1 (
    .clock(clk), .reset(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_error(rsp_error[1]), .busy(busy[1])
  );

  task automatic check(input string nm, input logic [66:0] act, input logic [66:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic int lat_of(input int k);
    return (k == 0) ? 3 : 1;
  endfunction

  // ---------------- transaction-level model ----------------
  // A request is outstanding from its accepting edge; its access lands on
  // edge (accept + LAT - 1); the response is then held until rsp_ready.
  bit          m_pend [2];
  bit          m_have [2];
  int          m_due  [2];
  bit          m_wr   [2];
  logic [63:0] m_addr [2];
  logic [63:0] m_wd   [2];
  logic [63:0] m_rdata[2];
  bit          m_err  [2];
  bit   [7:0]  mm     [2][1024];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_pend[k]  = 1'b0;
        m_have[k]  = 1'b0;
        m_rdata[k] = 64'd0;
        m_err[k]   = 1'b0;
      end else if (m_have[k]) begin
        if (rsp_ready[k]) m_have[k] = 1'b0;
      end else begin
        if (!m_pend[k] && req_valid[k]) begin
          m_pend[k] = 1'b1;
          m_due[k]  = cyc + lat_of(k) - 1;
          m_wr[k]   = req_write[k];
          m_addr[k] = req_addr[k];
          m_wd[k]   = req_wdata[k];
        end
        if (m_pend[k] && cyc == m_due[k]) begin
          m_pend[k]  = 1'b0;
          m_have[k]  = 1'b1;
          m_rdata[k] = 64'd0;
          if (m_addr[k] > 64'd1016) begin
            m_err[k] = 1'b1;
          end else begin
            m_err[k] = 1'b0;
            for (int i = 0; i < 8; i++) begin
              int idx;
              idx = int'(m_addr[k][9:0]) + i;
              if (m_wr[k]) mm[k][idx] = m_wd[k][8*i +: 8];
              else m_rdata[k][8*i +: 8] = mm[k][idx];
            end
          end
        end
      end
    end
    cyc = cyc + 1;
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      check((k == 0) ? "model_lat3" : "model_lat1",
            {req_ready[k], rsp_valid[k], busy[k], rsp_error[k], rsp_rdata[k]},
            {!m_pend[k] && !m_have[k], m_have[k], m_pend[k] || m_have[k], m_err[k], m_rdata[k]});
    end
  end

  // ---------------- stimulus helpers (instance 0) ----------------
  task automatic wait_accept0();
    bit ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      if (req_ready[0]) ok = 1'b1;
    end
    if (!ok) check("accept_timeout", 67'd0, 67'd1);
  endtask

  task automatic wait_rsp0();
    bit ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      if (rsp_valid[0]) ok = 1'b1;
    end
    if (!ok) check("rsp_timeout", 67'd0, 67'd1);
  endtask

  task automatic xact0(input bit wr, input logic [63:0] addr, input logic [63:0] wd,
                       output logic [63:0] rd, output bit er, output int lat_edges);
    int acc_edge;
    @(posedge clk); #2;
    req_valid[0] = 1'b1; req_write[0] = wr; req_addr[0] = addr; req_wdata[0] = wd;
    rsp_ready[0] = 1'b0;
    wait_accept0();
    @(posedge clk); #2;
    acc_edge     = cyc - 1;
    req_valid[0] = 1'b0;
    req_addr[0]  = ~addr;
    req_wdata[0] = ~wd;
    req_write[0] = ~wr;
    wait_rsp0();
    lat_edges = cyc - acc_edge;
    rd = rsp_rdata[0];
    er = rsp_error[0];
    @(posedge clk); #2 rsp_ready[0] = 1'b1;
    @(posedge clk); #2 rsp_ready[0] = 1'b0;
  endtask

  logic [63:0] rd;
  bit          er;
  int          lat;
  int          nv;

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0; req_write[k] = 1'b0;
      req_addr[k]  = 64'd0; req_wdata[k] = 64'd0;
    end
    rsp_ready[0] = 1'b0;
    rsp_ready[1] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {req_ready[0], rsp_valid[0], busy[0], rsp_error[0], rsp_rdata[0]},
          {1'b1, 1'b0, 1'b0, 1'b0, 64'd0});
    @(posedge clk); #2 rst = 1'b0;

    // Store then load
    xact0(1'b1, 64'h10, 64'h1122334455667788, rd, er, lat);
    check("store_latency", 67'(lat), 67'd3);
    check("store_rsp", {er, rd}, {1'b0, 64'd0});

    // Backpressure; a second request is held valid throughout
    @(posedge clk); #2;
    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 64'h10;
    wait_accept0();
    @(posedge clk); #2 req_addr[0] = 64'h11;
    wait_rsp0();
    check("load_10", {rsp_error[0], rsp_rdata[0]}, {1'b0, 64'h1122334455667788});
    for (int h = 0; h < 5; h++) begin
      @(negedge clk);
      check("bp_hold", {req_ready[0], rsp_valid[0], rsp_error[0], rsp_rdata[0]},
            {1'b0, 1'b1, 1'b0, 64'h1122334455667788});
    end
    @(posedge clk); #2 rsp_ready[0] = 1'b1;
    @(posedge clk); #2 rsp_ready[0] = 1'b0;
    @(negedge clk);
    check("idle_after_hs", {req_ready[0], busy[0]}, {1'b1, 1'b0});
    @(negedge clk);
    check("accept_after_hs", {req_ready[0], busy[0]}, {1'b0, 1'b1});
    @(posedge clk); #2 req_valid[0] = 1'b0;
    wait_rsp0();
    check("load_11", {rsp_error[0], rsp_rdata[0]}, {1'b0, 64'h0011223344556677});
    @(posedge clk); #2 rsp_ready[0] = 1'b1;
    @(posedge clk); #2 rsp_ready[0] = 1'b0;

    // Bounds
    xact0(1'b1, 64'h3F8, 64'h0123456789ABCDEF, rd, er, lat);
    xact0(1'b0, 64'h3F8, 64'd0, rd, er, lat);
    check("load_3f8", {er, rd}, {1'b0, 64'h0123456789ABCDEF});
    xact0(1'b0, 64'h3F9, 64'd0, rd, er, lat);
    check("load_3f9_err", {er, rd}, {1'b1, 64'd0});
    xact0(1'b1, 64'hFFFFFFFFFFFFFFFC, 64'hA5A5A5A5A5A5A5A5, rd, er, lat);
    check("store_high_err", {er, rd}, {1'b1, 64'd0});
    xact0(1'b0, 64'h3F8, 64'd0, rd, er, lat);
    check("load_3f8_again", {er, rd}, {1'b0, 64'h0123456789ABCDEF});

    // Reset one cycle after a store is accepted
    @(posedge clk); #2;
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 64'h20;
    req_wdata[0] = 64'hDEADBEEFDEADBEEF;
    wait_accept0();
    @(posedge clk); #2 req_valid[0] = 1'b0; rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    check("reset_wait", {req_ready[0], rsp_valid[0], busy[0], rsp_error[0], rsp_rdata[0]},
          {1'b1, 1'b0, 1'b0, 1'b0, 64'd0});
    xact0(1'b0, 64'h20, 64'd0, rd, er, lat);
    check("load_20_dropped", {er, rd}, {1'b0, 64'd0});

    // Reset while a committed store's response is held
    @(posedge clk); #2;
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 64'h30;
    req_wdata[0] = 64'hCAFEF00D12345678;
    wait_accept0();
    @(posedge clk); #2 req_valid[0] = 1'b0;
    wait_rsp0();
    @(posedge clk); #2 rst = 1'b1;
    @(negedge clk);
    check("resp_before_reset", 67'(rsp_valid[0]), 67'd1);
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    check("resp_dropped", {rsp_valid[0], busy[0]}, {1'b0, 1'b0});
    xact0(1'b0, 64'h30, 64'd0, rd, er, lat);
    check("load_30_kept", {er, rd}, {1'b0, 64'hCAFEF00D12345678});

    // LAT=1 instance, rsp_ready tied high, request valid held
    @(posedge clk); #2;
    req_valid[1] = 1'b1; req_write[1] = 1'b1; req_addr[1] = 64'h8;
    req_wdata[1] = 64'h8877665544332211;
    begin
      bit ok = 1'b0;
      for (int t = 0; t < 20 && !ok; t++) begin
        @(negedge clk);
        if (req_ready[1]) ok = 1'b1;
      end
      if (!ok) check("accept1_timeout", 67'd0, 67'd1);
    end
    @(posedge clk); #2;
    req_write[1] = 1'b0; req_wdata[1] = 64'd0;
    nv = 0;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      if (rsp_valid[1]) nv++;
      check("lat1_pattern", 67'(rsp_valid[1]), 67'((t % 2) == 0));
    end
    check("lat1_count", 67'(nv), 67'd4);
    check("lat1_load", {rsp_error[1], rsp_rdata[1]}, {1'b0, 64'd0} | 67'(rsp_valid[1] ? 64'd0 : 64'h8877665544332211));
    @(posedge clk); #2 req_valid[1] = 1'b0;
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
`default_nettype wire
